mem_arbiter: RTL and testbench

Two-port arbiter sharing the single unified instruction/data memory between the multicycle CPU control path (port 0) and the program loader/debug port (port 1). Each requester holds a request until it receives a one-cycle acknowledge. The arbiter serialises the accesses, drives the memory for a fixed access latency, and returns registered read data. The CPU control FSM stalls its fetch, load and store states until `ack0` is asserted.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 30 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM encodings, port indices and counter width shared by the
// unified-memory arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick with an optional owner hold
// that re-grants the previous owner for lock bursts.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic hold,
  output logic grant_valid,
  output logic grant_idx
);

  logic w_owner_req;

  assign w_owner_req = last_grant ? req1 : req0;

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT_CPU;
    if (hold && w_owner_req) begin
      grant_idx = last_grant;
    end else if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU (port 0) and loader (port 1) accesses onto one
// memory with fixed latency. Define MEM_ARB_LOCK_EN to add lock0/lock1 burst holds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    o_dbg_state
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  // Handshake: a port raises reqN with we/addr/wdata and holds them until ackN;
  // ackN pulses for one cycle (DONE), and req seen during DONE is ignored.
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;
  logic             r_win;
  logic             r_ack0;
  logic             r_ack1;
  logic [DW-1:0]    r_rdata0;
  logic [DW-1:0]    r_rdata1;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;

  logic w_hold;
  logic w_gnt_valid;
  logic w_gnt_idx;

`ifdef MEM_ARB_LOCK_EN
  logic r_hold;

  // The owner's lock is sampled in DONE and honoured only in the next IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= 1'b0;
    end else if (r_state == DONE) begin
      r_hold <= r_win ? lock1 : lock0;
    end else begin
      r_hold <= 1'b0;
    end
  end

  assign w_hold = r_hold;
`else
  assign w_hold = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last_grant),
    .hold        (w_hold),
    .grant_valid (w_gnt_valid),
    .grant_idx   (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= PORT_LDR;
      r_win        <= PORT_CPU;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state      <= ACCESS;
            r_cnt        <= '0;
            r_win        <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_mem_en     <= 1'b1;
            r_mem_we     <= w_gnt_idx ? we1 : we0;
            r_mem_addr   <= w_gnt_idx ? addr1 : addr0;
            r_mem_wdata  <= w_gnt_idx ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          if (r_cnt == LAT_C) begin
            if (!r_mem_we) begin
              if (r_win) r_rdata1 <= mem_rdata;
              else       r_rdata0 <= mem_rdata;
            end
            if (r_win) r_ack1 <= 1'b1;
            else       r_ack0 <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus checked cycle by cycle against
// a transaction-timing reference model; two extra instances cover MEM_LAT 1 and 15.
module tb_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (MEM_LAT = 2) ----------------
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
  logic [1:0]    lock = '0;
`endif
  logic          ack0, ack1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock[0]), .lock1(lock[1]),
`endif
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- latency sweep instances (MEM_LAT = 1, 15) ----------------
  logic [1:0]    s_req = '0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_rd_in = '0;
  logic [1:0]    s_ack0, s_ack1, s_en, s_we, s_busy;
  logic [DW-1:0] s_rdata0 [2];
  logic [DW-1:0] s_rdata1 [2];
  logic [DW-1:0] s_wdata_o [2];
  logic [AW-1:0] s_addr_o [2];
  logic [1:0]    s_dbg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(gi == 0 ? 1 : 15)) u_sw (
      .clk(clk), .reset_n(reset_n),
      .req0(s_req[gi]), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .addr0(s_addr), .addr1('0), .wdata0('0), .wdata1('0),
`ifdef MEM_ARB_LOCK_EN
      .lock0(1'b0), .lock1(1'b0),
`endif
      .ack0(s_ack0[gi]), .ack1(s_ack1[gi]), .rdata0(s_rdata0[gi]), .rdata1(s_rdata1[gi]),
      .mem_en(s_en[gi]), .mem_we(s_we[gi]), .mem_addr(s_addr_o[gi]), .mem_wdata(s_wdata_o[gi]),
      .mem_rdata(s_rd_in), .busy(s_busy[gi]), .o_dbg_state(s_dbg[gi])
    );
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model: last grant cycle + timing arithmetic ----------------
  int            m_g, m_next;
  logic          m_win, m_last, m_we, m_lock;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd0, m_rd1;
  logic [0:0]    exp_q[$];

  function automatic void model_reset();
    m_g = -1000; m_next = -1000;
    m_win = 1'b0; m_last = 1'b1; m_we = 1'b0; m_lock = 1'b0;
    m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    exp_q.delete();
  endfunction

  // Consumes the inputs of cycle cyc; leaves the model describing cycle cyc+1.
  task automatic model_step();
    logic w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (cyc == m_g + 1 + LAT && !m_we) begin
      if (m_win) m_rd1 = mem_rdata;
      else       m_rd0 = mem_rdata;
    end
`ifdef MEM_ARB_LOCK_EN
    if (cyc == m_g + 2 + LAT) m_lock = lock[m_win];
`endif
    if (cyc >= m_next && req != 2'b00) begin
      if (m_lock && cyc == m_g + 3 + LAT && req[m_win]) w = m_win;
      else if (req == 2'b11) w = ~m_last;
      else w = req[1];
      m_g = cyc; m_win = w; m_last = w; m_lock = 1'b0;
      m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w];
      m_next = cyc + 3 + LAT;
      exp_q.push_back(w);
    end
  endtask

  task automatic sb_pop(input logic p);
    check("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) check("sb_ack_port", p, exp_q.pop_front());
  endtask

  task automatic check_outputs();
    logic acc, dn;
    acc = (cyc >= m_g + 1) && (cyc <= m_g + 1 + LAT);
    dn  = (cyc == m_g + 2 + LAT);
    check("ack0", ack0, dn && !m_win);
    check("ack1", ack1, dn && m_win);
    check("rdata0", rdata0, m_rd0);
    check("rdata1", rdata1, m_rd1);
    check("mem_en", mem_en, cyc == m_g + 1);
    check("mem_we", mem_we, acc ? m_we : 1'b0);
    check("mem_addr", mem_addr, acc ? m_addr : '0);
    check("mem_wdata", mem_wdata, acc ? m_wdata : '0);
    check("busy", busy, acc || dn);
    check("state", dbg_state, acc ? 1 : (dn ? 2 : 0));
    if (ack0) sb_pop(1'b0);
    if (ack1) sb_pop(1'b1);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_single(input logic p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int rel);
    int t0;
    t0 = cyc;
    rel = -1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int k = 0; k < 12 && rel < 0; k++) begin
      advance();
      if ((p ? ack1 : ack0) == 1'b1) begin
        rel = cyc - t0;
        req[p] = 1'b0;
      end
    end
    advance();
  endtask

  task automatic sweep();
    int ack_c [2];
    int bcnt [2];
    logic [DW-1:0] hist [24];
    for (int i = 0; i < 2; i++) begin ack_c[i] = -1; bcnt[i] = 0; end
    s_addr = AW'($urandom);
    s_req = 2'b11;
    for (int k = 0; k < 22; k++) begin
      s_rd_in = DW'($urandom);
      hist[k] = s_rd_in;
      advance();
      for (int i = 0; i < 2; i++) begin
        if (s_busy[i]) bcnt[i]++;
        if (s_en[i]) check("sw_mem_addr", s_addr_o[i], s_addr);
        if (s_dbg[i] == 2'd2) check("sw_done_ack", s_ack0[i], 1'b1);
        check("sw_mem_we", s_we[i], 1'b0);
        check("sw_mem_wdata", s_wdata_o[i], 0);
        check("sw_ack1", s_ack1[i], 1'b0);
        check("sw_rdata1", s_rdata1[i], 0);
        if (s_ack0[i]) begin
          if (ack_c[i] < 0) ack_c[i] = k + 1;
          s_req[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 15;
      check("sw_ack_cycle", ack_c[i], lat + 2);
      check("sw_busy_cycles", bcnt[i], lat + 2);
      check("sw_rdata0", s_rdata0[i], hist[lat + 1]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rel, a0, a1, both, n1, n_ack;
    int rel_l [3];
    logic [2:0] p_l, exp_p;

    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
    model_reset();
    @(negedge clk);
    check_outputs();
    advance();
    advance();
    reset_n = 1'b1;

    sweep();

    // write on port 1 straight after reset: rdata1 must stay 0
    run_single(1'b1, 1'b1, 8'h3F, 16'h1234, rel);
    check("wr_ack_latency", rel, LAT + 2);
    check("wr_rdata1", rdata1, 0);

    // single read on port 0 with the memory returning BEEF
    mem_rdata = 16'hBEEF;
    run_single(1'b0, 1'b0, 8'h10, 16'h0, rel);
    check("rd_ack_latency", rel, LAT + 2);
    check("rd_rdata0", rdata0, 16'hBEEF);
    check("rd_rdata1", rdata1, 0);

    // reset in cycle 2 of a port-0 read
    mem_rdata = 16'h5A5A;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h22;
    advance();
    advance();
    #1 reset_n = 1'b0;
    #1 model_reset();
    check_outputs();
    advance();
    advance();
    req[0] = 1'b0;

    // release into a simultaneous request: port 0 first
    reset_n = 1'b1;
    req = 2'b11; we = 2'b00; addr[0] = 8'h44; addr[1] = 8'h88;
    rel = cyc; a0 = -1; a1 = -1; both = 0;
    for (int k = 0; k < 14; k++) begin
      mem_rdata = DW'($urandom);
      advance();
      if (ack0 && ack1) both++;
      if (ack0 && a0 < 0) begin a0 = cyc - rel; req[0] = 1'b0; end
      if (ack1 && a1 < 0) begin a1 = cyc - rel; req[1] = 1'b0; end
    end
    check("cf_ack0_cycle", a0, LAT + 2);
    check("cf_ack1_cycle", a1, 2 * LAT + 5);
    check("cf_ack_overlap", both, 0);

    // loader burst with lock1 versus plain round robin
    rel = cyc; n1 = 0; n_ack = 0; p_l = '0;
    for (int i = 0; i < 3; i++) rel_l[i] = -1;
    req[1] = 1'b1;
`ifdef MEM_ARB_LOCK_EN
    lock[1] = 1'b1;
    exp_p = 3'b011;
`else
    exp_p = 3'b101;
`endif
    for (int k = 0; k < 18; k++) begin
      if (k == 1) req[0] = 1'b1;
`ifdef MEM_ARB_LOCK_EN
      if (k == 6) lock[1] = 1'b0;
`endif
      mem_rdata = DW'($urandom);
      advance();
      if ((ack0 || ack1) && n_ack < 3) begin
        p_l[n_ack] = ack1;
        rel_l[n_ack] = cyc - rel;
        n_ack++;
      end
      if (ack1) begin n1++; if (n1 == 2) req[1] = 1'b0; end
      if (ack0) req[0] = 1'b0;
    end
    check("lk_ack_count", n_ack, 3);
    for (int i = 0; i < 3; i++) begin
      check("lk_ack_port", p_l[i], exp_p[i]);
      check("lk_ack_cycle", rel_l[i], i * (LAT + 3) + LAT + 2);
    end

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      mem_rdata = DW'($urandom);
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 99) < 35) begin
          req[p] = 1'b1;
          we[p] = 1'($urandom_range(0, 1));
          addr[p] = AW'($urandom);
          wdata[p] = DW'($urandom);
        end else if (req[p] && $urandom_range(0, 99) < 10) begin
          we[p] = 1'($urandom_range(0, 1));
          addr[p] = AW'($urandom);
          wdata[p] = DW'($urandom);
        end
`ifdef MEM_ARB_LOCK_EN
        lock[p] = 1'($urandom_range(0, 1));
`endif
      end
      advance();
      if (ack0) req[0] = 1'b0;
      if (ack1) req[1] = 1'b0;
    end

    req = 2'b00;
`ifdef MEM_ARB_LOCK_EN
    lock = 2'b00;
`endif
    for (int k = 0; k < 12; k++) advance();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
